// File: rtl/branch_pkg.sv
// Shared types for the EX branch resolver: prediction entry, FSM state, PC increment.
// Optional performance counters in the resolver are enabled by defining BRANCH_PERF_CNT_EN.
package branch_pkg;

    // Storage width of a PC inside a prediction entry; resolver PC_W must not exceed it.
    localparam int BR_PC_W = 32;
    localparam int unsigned PC_INCR = 4;

    typedef struct packed {
        logic               pred_take;
        logic [BR_PC_W-1:0] pc;
        logic [BR_PC_W-1:0] target;
    } pred_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_pred_fifo.sv
// Circular FIFO of outstanding branch predictions; pointers carry one extra wrap bit.
module branch_pred_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        clear_i,
    input  pred_entry_t wdata_i,
    output pred_entry_t rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    pred_entry_t    mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ex_branch_resolver.sv
// Resolves queued IF predictions in EX, returns registered predictor feedback, drives flush/redirect.
// Defining BRANCH_PERF_CNT_EN adds saturating branch_count / mispredict_count outputs.
module ex_branch_resolver
    import branch_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W         = BR_PC_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_push,
    input  logic            if_pred_take,
    input  logic [PC_W-1:0] if_pc,
    input  logic [PC_W-1:0] if_target,
    output logic            queue_full,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_unconditional_jmp,
    input  logic            ex_zero,
    input  logic [PC_W-1:0] ex_target,
    output logic            pc_jmp_feedback,
    output logic            pc_jmp_take,
    output logic [PC_W-1:0] pc_stash_base,
    output logic [PC_W-1:0] pc_jmp,
    output logic            flush,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            err
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
`endif
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    br_state_e       state_q;
    logic [CW-1:0]   flush_cnt_q;
    logic            flush_q;
    logic            fb_valid_q;
    logic            fb_take_q;
    logic [PC_W-1:0] fb_base_q;
    logic [PC_W-1:0] fb_jmp_q;
    logic            redirect_valid_q;
    logic [PC_W-1:0] redirect_pc_q;
    logic            err_q;

    pred_entry_t     head;
    pred_entry_t     wentry;
    logic            fifo_full;
    logic            fifo_empty;

    logic            idle;
    logic            resolve;
    logic            actual_take;
    logic [PC_W-1:0] head_pc;
    logic [PC_W-1:0] head_tgt;
    logic [PC_W-1:0] actual_pc;
    logic            mispredict;
    logic            push_req;
    logic            push_drop;
    logic            empty_resolve;

    assign idle        = (state_q == IDLE);
    assign resolve     = idle && ex_valid && !fifo_empty;
    assign actual_take = ex_unconditional_jmp | (ex_branch & ex_zero);
    assign head_pc     = head.pc[PC_W-1:0];
    assign head_tgt    = head.target[PC_W-1:0];
    assign actual_pc   = actual_take ? ex_target : head_pc + PC_W'(PC_INCR);
    assign mispredict  = resolve &&
                         ((actual_take != head.pred_take) || (actual_take && (ex_target != head_tgt)));

    // A push alongside a mispredict belongs to the wrong path and is dropped with the flush.
    assign push_req      = idle && if_push && !mispredict;
    assign push_drop     = idle && if_push && fifo_full && !resolve;
    assign empty_resolve = idle && ex_valid && fifo_empty;

    assign wentry.pred_take = if_pred_take;
    assign wentry.pc        = BR_PC_W'(if_pc);
    assign wentry.target    = BR_PC_W'(if_target);

    branch_pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .pop_i   (resolve),
        .clear_i (mispredict),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            flush_cnt_q      <= '0;
            flush_q          <= 1'b0;
            fb_valid_q       <= 1'b0;
            fb_take_q        <= 1'b0;
            fb_base_q        <= '0;
            fb_jmp_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            err_q            <= 1'b0;
        end else begin
            fb_valid_q       <= resolve;
            redirect_valid_q <= mispredict;
            if (resolve) begin
                fb_take_q <= actual_take;
                fb_base_q <= head_pc;
                fb_jmp_q  <= actual_pc;
            end
            if (mispredict) redirect_pc_q <= actual_pc;
            if (push_drop || empty_resolve) err_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (mispredict) begin
                        state_q     <= FLUSH;
                        flush_q     <= 1'b1;
                        flush_cnt_q <= CW'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign queue_full      = fifo_full;
    assign pc_jmp_feedback = fb_valid_q;
    assign pc_jmp_take     = fb_take_q;
    assign pc_stash_base   = fb_base_q;
    assign pc_jmp          = fb_jmp_q;
    assign flush           = flush_q;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign err             = err_q;

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (resolve && (branch_count_q != '1))        branch_count_q     <= branch_count_q + 1'b1;
            if (mispredict && (mispredict_count_q != '1)) mispredict_count_q <= mispredict_count_q + 1'b1;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_ex_branch_resolver.sv
// Directed scoreboard bench: stimulus queues expected feedback/redirects, a negedge monitor checks them.
module tb_ex_branch_resolver;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_push;
    logic        if_pred_take;
    logic [31:0] if_pc;
    logic [31:0] if_target;
    logic        queue_full;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_unconditional_jmp;
    logic        ex_zero;
    logic [31:0] ex_target;
    logic        pc_jmp_feedback;
    logic        pc_jmp_take;
    logic [31:0] pc_stash_base;
    logic [31:0] pc_jmp;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        err;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
`endif

    always #5 clk = ~clk;

    ex_branch_resolver #(
        .DEPTH        (4),
        .FLUSH_CYCLES (2),
        .PC_W         (32)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .if_push              (if_push),
        .if_pred_take         (if_pred_take),
        .if_pc                (if_pc),
        .if_target            (if_target),
        .queue_full           (queue_full),
        .ex_valid             (ex_valid),
        .ex_branch            (ex_branch),
        .ex_unconditional_jmp (ex_unconditional_jmp),
        .ex_zero              (ex_zero),
        .ex_target            (ex_target),
        .pc_jmp_feedback      (pc_jmp_feedback),
        .pc_jmp_take          (pc_jmp_take),
        .pc_stash_base        (pc_stash_base),
        .pc_jmp               (pc_jmp),
        .flush                (flush),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .err                  (err)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .branch_count         (branch_count),
        .mispredict_count     (mispredict_count)
`endif
    );

    typedef struct {
        logic        take;
        logic [31:0] base;
        logic [31:0] jmp;
    } fb_exp_t;

    fb_exp_t     fb_q[$];
    logic [31:0] rd_q[$];
    fb_exp_t     mon_fb;
    logic [31:0] mon_rd;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every feedback / redirect pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (pc_jmp_feedback) begin
            if (fb_q.size() == 0) begin
                check("fb_unexpected", 64'(pc_jmp_feedback), 64'd0);
            end else begin
                mon_fb = fb_q.pop_front();
                check("fb_take", 64'(pc_jmp_take), 64'(mon_fb.take));
                check("fb_stash_base", 64'(pc_stash_base), 64'(mon_fb.base));
                check("fb_pc_jmp", 64'(pc_jmp), 64'(mon_fb.jmp));
            end
        end
        if (redirect_valid) begin
            if (rd_q.size() == 0) begin
                check("redirect_unexpected", 64'(redirect_valid), 64'd0);
            end else begin
                mon_rd = rd_q.pop_front();
                check("redirect_pc", 64'(redirect_pc), 64'(mon_rd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        if_push              = 1'b0;
        if_pred_take         = 1'b0;
        if_pc                = '0;
        if_target            = '0;
        ex_valid             = 1'b0;
        ex_branch            = 1'b0;
        ex_unconditional_jmp = 1'b0;
        ex_zero              = 1'b0;
        ex_target            = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic drive_push(input logic take, input logic [31:0] pc, input logic [31:0] tgt);
        if_push      = 1'b1;
        if_pred_take = take;
        if_pc        = pc;
        if_target    = tgt;
    endtask

    task automatic drive_resolve(input logic br, input logic uj, input logic zero, input logic [31:0] tgt);
        ex_valid             = 1'b1;
        ex_branch            = br;
        ex_unconditional_jmp = uj;
        ex_zero              = zero;
        ex_target            = tgt;
    endtask

    task automatic expect_fb(input logic take, input logic [31:0] base, input logic [31:0] jmp);
        fb_exp_t e;
        e.take = take;
        e.base = base;
        e.jmp  = jmp;
        fb_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [31:0] drain_pcs [4];

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_queue_full", 64'(queue_full), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_feedback", 64'(pc_jmp_feedback), 64'd0);
        check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        check("rst_pc_jmp", 64'(pc_jmp), 64'd0);
        check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        reset = 1'b0;

        // Correct taken prediction.
        drive_push(1'b1, 32'h100, 32'h200);
        step();
        drive_resolve(1'b1, 1'b0, 1'b1, 32'h200);
        expect_fb(1'b1, 32'h100, 32'h200);
        step();
        check("t1_feedback_pulse", 64'(pc_jmp_feedback), 64'd1);
        check("t1_flush", 64'(flush), 64'd0);
        step();
        check("t1_feedback_drop", 64'(pc_jmp_feedback), 64'd0);
        check("t1_base_held", 64'(pc_stash_base), 64'h100);

        // Direction mispredict: flush lasts exactly two cycles, FIFO empty afterwards.
        drive_push(1'b1, 32'h100, 32'h200);
        step();
        drive_resolve(1'b1, 1'b0, 1'b0, 32'h200);
        expect_fb(1'b0, 32'h100, 32'h104);
        rd_q.push_back(32'h104);
        step();
        check("t2_flush_c1", 64'(flush), 64'd1);
        check("t2_redirect_pulse", 64'(redirect_valid), 64'd1);
        step();
        check("t2_flush_c2", 64'(flush), 64'd1);
        check("t2_redirect_drop", 64'(redirect_valid), 64'd0);
        step();
        check("t2_flush_end", 64'(flush), 64'd0);
        drive_push(1'b0, 32'h500, 32'h600);
        step();
        drive_resolve(1'b1, 1'b0, 1'b0, 32'h0);
        expect_fb(1'b0, 32'h500, 32'h504);
        step();
        step();

        // Fill, overflow drop, push+pop while full, then drain.
        for (int i = 1; i <= 4; i++) begin
            drive_push(1'b0, 32'(i * 16), 32'h0);
            step();
        end
        check("t3_full", 64'(queue_full), 64'd1);
        check("t3_err_before", 64'(err), 64'd0);
        drive_push(1'b0, 32'h50, 32'h0);
        step();
        check("t3_err_overflow", 64'(err), 64'd1);
        check("t3_full_after_drop", 64'(queue_full), 64'd1);
        drive_push(1'b0, 32'h60, 32'h0);
        drive_resolve(1'b0, 1'b0, 1'b0, 32'h0);
        expect_fb(1'b0, 32'h10, 32'h14);
        step();
        check("t3_full_pushpop", 64'(queue_full), 64'd1);
        drain_pcs[0] = 32'h20;
        drain_pcs[1] = 32'h30;
        drain_pcs[2] = 32'h40;
        drain_pcs[3] = 32'h60;
        for (int i = 0; i < 4; i++) begin
            drive_resolve(1'b0, 1'b0, 1'b0, 32'h0);
            expect_fb(1'b0, drain_pcs[i], drain_pcs[i] + 32'd4);
            step();
        end
        check("t3_drained", 64'(queue_full), 64'd0);
        do_reset();
        check("t3_err_cleared", 64'(err), 64'd0);

        // Target mispredict on an unconditional jump; same-cycle and in-flush pushes discarded.
        drive_push(1'b1, 32'h80, 32'h300);
        step();
        drive_resolve(1'b0, 1'b1, 1'b0, 32'h340);
        drive_push(1'b1, 32'h90, 32'h999);
        expect_fb(1'b1, 32'h80, 32'h340);
        rd_q.push_back(32'h340);
        step();
        check("t4_flush_c1", 64'(flush), 64'd1);
        drive_push(1'b0, 32'hB0, 32'h0);
        drive_resolve(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check("t4_flush_c2", 64'(flush), 64'd1);
        step();
        check("t4_flush_end", 64'(flush), 64'd0);
        check("t4_err_clear", 64'(err), 64'd0);
        drive_push(1'b0, 32'hA0, 32'h0);
        step();
        drive_resolve(1'b0, 1'b0, 1'b0, 32'h0);
        expect_fb(1'b0, 32'hA0, 32'hA4);
        step();
        step();

        // Fall-through PC wraps to zero.
        drive_push(1'b1, 32'hFFFF_FFFC, 32'h8);
        step();
        drive_resolve(1'b1, 1'b0, 1'b0, 32'h8);
        expect_fb(1'b0, 32'hFFFF_FFFC, 32'h0);
        rd_q.push_back(32'h0);
        step();
        step();
        step();

        // Resolve on an empty FIFO: error, no feedback.
        drive_resolve(1'b1, 1'b0, 1'b1, 32'h10);
        step();
        check("t6_err_empty", 64'(err), 64'd1);
        check("t6_no_feedback", 64'(pc_jmp_feedback), 64'd0);

        // Reset in the middle of a flush.
        drive_push(1'b1, 32'h700, 32'h800);
        step();
        drive_push(1'b1, 32'h710, 32'h800);
        step();
        drive_resolve(1'b1, 1'b0, 1'b0, 32'h0);
        expect_fb(1'b0, 32'h700, 32'h704);
        rd_q.push_back(32'h704);
        step();
        check("t6_in_flush", 64'(flush), 64'd1);
        reset = 1'b1;
        drive_resolve(1'b1, 1'b0, 1'b1, 32'h0);
        step();
        check("t6_rst_flush", 64'(flush), 64'd0);
        check("t6_rst_full", 64'(queue_full), 64'd0);
        check("t6_rst_err", 64'(err), 64'd0);
        check("t6_rst_feedback", 64'(pc_jmp_feedback), 64'd0);
        reset = 1'b0;

        // Reset with entries pending, including a same-cycle resolve.
        for (int i = 0; i < 4; i++) begin
            drive_push(1'b0, 32'h900 + 32'(i * 16), 32'h0);
            step();
        end
        check("t7_full_pre", 64'(queue_full), 64'd1);
        reset = 1'b1;
        drive_resolve(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check("t7_rst_full", 64'(queue_full), 64'd0);
        check("t7_rst_feedback", 64'(pc_jmp_feedback), 64'd0);
        reset = 1'b0;
        drive_push(1'b0, 32'h920, 32'h0);
        step();
        drive_resolve(1'b0, 1'b0, 1'b0, 32'h0);
        expect_fb(1'b0, 32'h920, 32'h924);
        step();
        step();
        step();

        check("fb_queue_empty", 64'(fb_q.size()), 64'd0);
        check("redirect_queue_empty", 64'(rd_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_branch_resolver.md
Name: ex_branch_resolver

Overview:
- EX-stage end of the branch-prediction interface.
- Holds a FIFO of predictions issued by IF and resolves each one when its branch reaches EX.
- Returns registered feedback (`pc_jmp_feedback`, `pc_jmp_take`, `pc_stash_base`, `pc_jmp`) to the IF predictor.
- On a mispredict, drives the pipeline flush and the PC redirect.

Parameters:
- DEPTH, 4: prediction FIFO entries; power of two, ≥2.
- FLUSH_CYCLES, 2: cycles `flush` stays high after a mispredict; ≥1.
- PC_W, 32: PC width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- if_push  in  1  IF issued a prediction for a branch/jump this cycle
- if_pred_take  in  1  predicted direction
- if_pc  in  PC_W  PC of the branch instruction
- if_target  in  PC_W  predicted target
- queue_full  out  1  FIFO full; IF must stall branch issue
- ex_valid  in  1  EX resolves the oldest outstanding branch this cycle
- ex_branch  in  1  conditional branch
- ex_unconditional_jmp  in  1  unconditional jump
- ex_zero  in  1  branch condition result
- ex_target  in  PC_W  computed target
- pc_jmp_feedback  out  1  one-cycle feedback pulse to predictor
- pc_jmp_take  out  1  actual direction
- pc_stash_base  out  PC_W  PC of the resolved branch
- pc_jmp  out  PC_W  actual target
- flush  out  1  squash IF/ID/EX younger instructions
- redirect_valid  out  1  one-cycle pulse; load `redirect_pc`
- redirect_pc  out  PC_W  correct next PC
- err  out  1  sticky: push while full, or `ex_valid` with FIFO empty

Behaviour:
- Reset: FIFO empty, FSM in IDLE, counters 0, all outputs 0.
- FIFO: circular, write/read pointers with one extra wrap bit.
  - full = pointers differ only in the MSB.
  - `queue_full` is combinational from the pointers.
- Push:
  - If not full: enqueue {`if_pred_take`, `if_pc`, `if_target`}.
  - If full with no pop in the same cycle: drop the entry and set `err`.
  - If full with a pop in the same cycle: the push is accepted.
- Resolve (IDLE, `ex_valid`, FIFO not empty):
  - actual_take = `ex_unconditional_jmp` | (`ex_branch` & `ex_zero`).
  - mispredict = (actual_take != head.pred_take) | (actual_take & (`ex_target` != head.target)).
  - The head entry is popped.
- `ex_valid` with FIFO empty: no pop, no feedback, `err` set.
- Feedback has latency 1. The cycle after a resolve:
  - `pc_jmp_feedback` = 1
  - `pc_jmp_take` = actual_take
  - `pc_stash_base` = head.pc
  - `pc_jmp` = actual_take ? `ex_target` : head.pc+4
  - The feedback registers are held otherwise; `pc_jmp_feedback` = 0 otherwise.
- Mispredict, registered with the same latency 1:
  - `redirect_valid` = 1 for one cycle.
  - `redirect_pc` = actual_take ? `ex_target` : head.pc+4.
  - `flush` = 1.
  - FIFO cleared; the same-cycle push is discarded because it is a younger, wrong-path instruction.
  - FSM moves to FLUSH.
- FSM:
  - IDLE → FLUSH on mispredict; counter loaded with FLUSH_CYCLES-1.
  - FLUSH: `flush` = 1; `if_push` and `ex_valid` ignored; counter decrements.
  - FLUSH → IDLE when counter = 0; `flush` drops the following cycle.
  - `flush` is high exactly FLUSH_CYCLES cycles.
- PC+4 arithmetic is modulo 2^PC_W (wrap without error).
- Reset mid-FLUSH or with entries pending: everything returns to reset state on the next edge, and no feedback is emitted.
- Correct prediction: feedback only; no flush, no redirect.

Optional Feature:
- BRANCH_PERF_CNT_EN: defined → add outputs `branch_count` [31:0] and `mispredict_count` [31:0].
  - `branch_count` increments on each valid resolve; `mispredict_count` increments on each mispredict.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined → ports and logic absent.

Decomposition:
- Shared package `branch_pkg`:
  - Prediction entry typedef {pred_take, pc, target}.
  - FSM state enum {IDLE, FLUSH}.
  - Constant PC_INCR = 4.
- One sub-module, `branch_pred_fifo` (DEPTH/PC_W, push/pop/clear/full/empty); resolution, FSM and feedback registers stay in the top.

Test Plan:
- Push {take=1, pc=0x100, tgt=0x200}; ex_valid, ex_branch=1, ex_zero=1, ex_target=0x200 → next cycle feedback=1, take=1, stash_base=0x100, pc_jmp=0x200; flush=0, redirect_valid=0.
- Push {take=1, pc=0x100, tgt=0x200}; resolve with ex_zero=0 → redirect_valid pulse, redirect_pc=0x104, flush high exactly 2 cycles, FIFO empty afterwards, pc_jmp_take=0.
- Push 4 entries → queue_full=1. Push a 5th with no pop → err=1, entry dropped. Push and pop in the same cycle while full → accepted, queue_full stays 1.
- Unconditional jump predicted take with tgt=0x300, ex_target=0x340 → target mismatch → redirect_pc=0x340, flush, same-cycle push discarded.
- pc=0xFFFFFFFC predicted take, actually not taken → redirect_pc=0x00000000.
- Reset asserted during FLUSH with 2 entries queued → next cycle flush=0, FIFO empty, queue_full=0, err=0, no feedback pulse.
